// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_EXT = 1'b1;

  localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester, memory and stall signals between the arbiter and its surroundings.
interface dmem_arbiter_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) ();

  logic          m0_req_i;
  logic          m0_we_i;
  logic [AW-1:0] m0_addr_i;
  logic [DW-1:0] m0_wdata_i;
  logic          m0_done_o;
  logic [DW-1:0] m0_rdata_o;

  logic          m1_req_i;
  logic          m1_we_i;
  logic [AW-1:0] m1_addr_i;
  logic [DW-1:0] m1_wdata_i;
  logic          m1_done_o;
  logic [DW-1:0] m1_rdata_o;

  logic          stall_o;

  logic          mem_en_o;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [DW-1:0] mem_rdata_i;

  // Requesters and the memory together form the master side.
  modport master (
    output m0_req_i, m0_we_i, m0_addr_i, m0_wdata_i,
    output m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i,
    output mem_rdata_i,
    input  m0_done_o, m0_rdata_o, m1_done_o, m1_rdata_o, stall_o,
    input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

  modport slave (
    input  m0_req_i, m0_we_i, m0_addr_i, m0_wdata_i,
    input  m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i,
    input  mem_rdata_i,
    output m0_done_o, m0_rdata_o, m1_done_o, m1_rdata_o, stall_o,
    output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin pick: the pointer breaks ties when both requesters are active.
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       ptr_i,
  output logic       gnt_id_c,
  output logic       gnt_vld_c
);

  always_comb begin
    gnt_vld_c = |req_i;
    gnt_id_c  = (&req_i) ? ptr_i : req_i[1];
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin data-memory arbiter between the MEM stage (m0) and an external master (m1).
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned AW  = 32,
  parameter int unsigned DW  = 32,
  parameter int unsigned LAT = 1
) (
  input  logic           clk_i,
  input  logic           rst_i,
  dmem_arbiter_if.slave  bus
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ptr_q, ptr_d;
  logic             owner_q, owner_d;
  logic             we_q, we_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [DW-1:0]    wdata_q, wdata_d;
  logic [DW-1:0]    rdata0_q, rdata0_d;
  logic [DW-1:0]    rdata1_q, rdata1_d;
  logic             done0_q, done0_d;
  logic             done1_q, done1_d;
  logic             mem_en_q, mem_en_d;

  logic             gnt_id;
  logic             gnt_vld;

  rr_arb2 u_rr_arb2 (
    .req_i     ({bus.m1_req_i, bus.m0_req_i}),
    .ptr_i     (ptr_q),
    .gnt_id_c  (gnt_id),
    .gnt_vld_c (gnt_vld)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ptr_q    <= REQ_CPU;
      owner_q  <= REQ_CPU;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      mem_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      mem_en_q <= mem_en_d;
    end
  end

  // The latched access copy doubles as the memory bus and is cleared outside BUSY.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    mem_en_d = mem_en_q;

    case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          owner_d  = gnt_id;
          we_d     = (gnt_id == REQ_EXT) ? bus.m1_we_i    : bus.m0_we_i;
          addr_d   = (gnt_id == REQ_EXT) ? bus.m1_addr_i  : bus.m0_addr_i;
          wdata_d  = (gnt_id == REQ_EXT) ? bus.m1_wdata_i : bus.m0_wdata_i;
          cnt_d    = CNT_W'(LAT - 1);
          ptr_d    = ~gnt_id;
          mem_en_d = 1'b1;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          if (!we_q) begin
            if (owner_q == REQ_EXT) rdata1_d = bus.mem_rdata_i;
            else                    rdata0_d = bus.mem_rdata_i;
          end
          we_d     = 1'b0;
          addr_d   = '0;
          wdata_d  = '0;
          mem_en_d = 1'b0;
          done0_d  = (owner_q == REQ_CPU);
          done1_d  = (owner_q == REQ_EXT);
          state_d  = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.mem_en_o    = mem_en_q;
  assign bus.mem_we_o    = we_q;
  assign bus.mem_addr_o  = addr_q;
  assign bus.mem_wdata_o = wdata_q;
  assign bus.m0_done_o   = done0_q;
  assign bus.m1_done_o   = done1_q;
  assign bus.m0_rdata_o  = rdata0_q;
  assign bus.m1_rdata_o  = rdata1_q;
  assign bus.stall_o     = bus.m0_req_i & ~done0_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a vector table of single transactions plus hand-written corner cases.
module tb_dmem_arbiter;

  localparam int unsigned LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic preload = 1'b1;

  always #5 clk = ~clk;

  dmem_arbiter_if #(.AW(32), .DW(32)) bus ();

  dmem_arbiter #(.AW(32), .DW(32), .LAT(LAT)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // Word-addressed backing memory, independent of the arbiter's reset.
  logic [31:0] mem [0:63];
  assign bus.mem_rdata_i = mem[6'(bus.mem_addr_o >> 2)];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      mem[4]  <= 32'hDEADBEEF;
      mem[8]  <= 32'h11111111;
      mem[12] <= 32'hCAFEF00D;
    end else if (bus.mem_en_o && bus.mem_we_o) begin
      mem[6'(bus.mem_addr_o >> 2)] <= bus.mem_wdata_o;
    end
  end

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive_req(input logic who, input logic req, input logic we,
                           input logic [31:0] addr, input logic [31:0] wdata);
    if (who) begin
      bus.m1_req_i = req; bus.m1_we_i = we; bus.m1_addr_i = addr; bus.m1_wdata_i = wdata;
    end else begin
      bus.m0_req_i = req; bus.m0_we_i = we; bus.m0_addr_i = addr; bus.m0_wdata_i = wdata;
    end
  endtask

  typedef struct {
    logic        who;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd0;
    logic [31:0] exp_rd1;
  } vec_t;

  // One isolated transaction from an idle arbiter; checks bus, timing and both rdata registers.
  task automatic run_txn(input vec_t v, input string tag);
    int en_cnt = 0;
    int stall_cnt = 0;
    int done_c = 0;
    @(negedge clk);
    drive_req(v.who, 1'b1, v.we, v.addr, v.wdata);
    #1;
    if (!v.who) check({tag, " stall_on_req"}, 32'(bus.stall_o), 32'd1);
    for (int c = 1; c <= int'(LAT) + 4; c++) begin
      @(negedge clk);
      if (bus.mem_en_o) begin
        en_cnt++;
        check({tag, " mem_addr"}, bus.mem_addr_o, v.addr);
        check({tag, " mem_we"}, 32'(bus.mem_we_o), 32'(v.we));
        if (v.we) check({tag, " mem_wdata"}, bus.mem_wdata_o, v.wdata);
      end
      if (bus.stall_o) stall_cnt++;
      if (v.who ? bus.m1_done_o : bus.m0_done_o) begin
        done_c = c;
        break;
      end
    end
    drive_req(v.who, 1'b0, 1'b0, 32'h0, 32'h0);
    check({tag, " done_cycle"}, 32'(done_c), 32'(LAT + 1));
    check({tag, " en_cycles"}, 32'(en_cnt), 32'(LAT));
    if (!v.who) check({tag, " stall_cycles"}, 32'(stall_cnt), 32'(LAT));
    check({tag, " rdata0"}, bus.m0_rdata_o, v.exp_rd0);
    check({tag, " rdata1"}, bus.m1_rdata_o, v.exp_rd1);
  endtask

  vec_t vecs [6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, d1, k, dones, ens;
    logic [31:0] got [4];
    int t [4];

    vecs[0] = '{1'b0, 1'b0, 32'h10, 32'h0,    32'hDEADBEEF, 32'h0};
    vecs[1] = '{1'b1, 1'b0, 32'h30, 32'h0,    32'hDEADBEEF, 32'hCAFEF00D};
    vecs[2] = '{1'b1, 1'b1, 32'h20, 32'h55,   32'hDEADBEEF, 32'hCAFEF00D};
    vecs[3] = '{1'b1, 1'b0, 32'h20, 32'h0,    32'hDEADBEEF, 32'h55};
    vecs[4] = '{1'b0, 1'b1, 32'h30, 32'hA5A5, 32'hDEADBEEF, 32'h55};
    vecs[5] = '{1'b0, 1'b0, 32'h30, 32'h0,    32'hA5A5,     32'h55};

    drive_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive_req(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);

    // Reset state
    check("rst mem_en",  32'(bus.mem_en_o), 32'd0);
    check("rst mem_addr", bus.mem_addr_o, 32'h0);
    check("rst done0",   32'(bus.m0_done_o), 32'd0);
    check("rst done1",   32'(bus.m1_done_o), 32'd0);
    check("rst rdata0",  bus.m0_rdata_o, 32'h0);
    check("rst rdata1",  bus.m1_rdata_o, 32'h0);
    check("rst stall",   32'(bus.stall_o), 32'd0);
    preload = 1'b0;
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // Simultaneous requests right after reset: m0 first, m1 LAT+2 later
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    drive_req(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
    drive_req(1'b1, 1'b1, 1'b0, 32'h30, 32'h0);
    d0 = 0; d1 = 0;
    for (int c = 1; c <= 20 && d1 == 0; c++) begin
      @(negedge clk);
      if (bus.m0_done_o) begin
        d0 = c;
        check("both rdata0", bus.m0_rdata_o, 32'hDEADBEEF);
        drive_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      end
      if (bus.m1_done_o) begin
        d1 = c;
        check("both rdata1", bus.m1_rdata_o, 32'hA5A5);
        drive_req(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      end
    end
    drive_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive_req(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    check("both m0_done_cycle", 32'(d0), 32'(LAT + 1));
    check("both m1_done_cycle", 32'(d1), 32'(2 * LAT + 3));

    // Continuous contention: grants must alternate 0,1,0,1 at LAT+2 spacing
    @(negedge clk);
    drive_req(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
    drive_req(1'b1, 1'b1, 1'b0, 32'h30, 32'h0);
    k = 0;
    for (int i = 0; i < 4; i++) begin got[i] = 32'hFFFF; t[i] = 0; end
    for (int c = 1; c <= 40 && k < 4; c++) begin
      @(negedge clk);
      if (bus.m0_done_o) begin got[k] = 32'd0; t[k] = c; k++; end
      else if (bus.m1_done_o) begin got[k] = 32'd1; t[k] = c; k++; end
    end
    drive_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive_req(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    check("rr owner0", got[0], 32'd0);
    check("rr owner1", got[1], 32'd1);
    check("rr owner2", got[2], 32'd0);
    check("rr owner3", got[3], 32'd1);
    for (int i = 1; i < 4; i++) check($sformatf("rr spacing%0d", i), 32'(t[i] - t[i-1]), 32'(LAT + 2));

    // Inputs changing and req dropping during BUSY do not disturb the access
    @(negedge clk);
    drive_req(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
    d0 = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) drive_req(1'b0, 1'b0, 1'b1, 32'h30, 32'h00000BAD);
      if (bus.mem_en_o) begin
        check("hold mem_addr", bus.mem_addr_o, 32'h10);
        check("hold mem_we", 32'(bus.mem_we_o), 32'd0);
      end
      if (bus.m0_done_o) begin d0 = c; break; end
    end
    drive_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    check("hold done_cycle", 32'(d0), 32'(LAT + 1));
    check("hold rdata0", bus.m0_rdata_o, 32'hDEADBEEF);

    // Reset in the middle of BUSY aborts the access without a done pulse
    @(negedge clk);
    drive_req(1'b1, 1'b1, 1'b0, 32'h30, 32'h0);
    @(negedge clk);
    check("abort pre mem_en", 32'(bus.mem_en_o), 32'd1);
    rst = 1'b1;
    #1;
    check("abort mem_en",   32'(bus.mem_en_o), 32'd0);
    check("abort mem_addr", bus.mem_addr_o, 32'h0);
    check("abort done1",    32'(bus.m1_done_o), 32'd0);
    check("abort rdata0",   bus.m0_rdata_o, 32'h0);
    check("abort rdata1",   bus.m1_rdata_o, 32'h0);
    drive_req(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk); rst = 1'b0;
    dones = 0; ens = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus.m0_done_o || bus.m1_done_o) dones++;
      if (bus.mem_en_o) ens++;
    end
    check("abort no_done", 32'(dones), 32'd0);
    check("abort no_en", 32'(ens), 32'd0);
    run_txn('{1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 32'h0}, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
